// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bundles the handshake and memory signals of the instruction
//               fetch stage.
//               master modport : the fetch stage (drives the memory address,
//                                the instruction and the status outputs)
//               slave modport  : the surrounding environment (sequencer,
//                                memory, decoder)
//               Fetch control  : fetch_req, pc_load, pc_next, kernel_flag,
//                                fault_clr
//               Memory side    : mem_addr, mem_rd, mem_rdata, acc_inv
//               Decoder side   : instr, instr_valid, instr_pc, instr_ready
//               Status         : pc, busy, fault
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic        fetch_req;
  logic        pc_load;
  logic [15:0] pc_next;
  logic        kernel_flag;
  logic [15:0] mem_rdata;
  logic        acc_inv;
  logic        fault_clr;
  logic        instr_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] pc;
  logic        busy;
  logic        fault;

  modport master (
    input  fetch_req, pc_load, pc_next, kernel_flag, mem_rdata, acc_inv,
           fault_clr, instr_ready,
    output mem_addr, mem_rd, instr, instr_valid, instr_pc, pc, busy, fault
  );

  modport slave (
    output fetch_req, pc_load, pc_next, kernel_flag, mem_rdata, acc_inv,
           fault_clr, instr_ready,
    input  mem_addr, mem_rd, instr, instr_valid, instr_pc, pc, busy, fault
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC, issues a one-cycle
//               read strobe to memory, waits MEM_LATENCY clocks, captures the
//               16-bit word into the instruction register and presents it to
//               the decoder with a valid/ready handshake. An AccInv response
//               raises a sticky fault.
//               Optional macro FETCH_KERNEL_CHECK_EN: user-mode fetches below
//               USER_BASE fault immediately without touching memory.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - fetch_stage_if.master (control, memory, decoder and
//                      status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h3000,
  parameter int          MEM_LATENCY = 1,
  parameter logic [15:0] USER_BASE   = 16'h3000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fetch_stage_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Counter reloads with MEM_LATENCY-1 so capture happens MEM_LATENCY clocks
  // after the read strobe; two bits cover latencies 1..4.
  localparam logic [1:0] c_CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic [15:0] r_instr_pc;
  logic        r_busy;
  logic        r_fault;
  logic [1:0]  r_cnt;

  logic        w_priv_fault;

`ifdef FETCH_KERNEL_CHECK_EN
  assign w_priv_fault = !bus.kernel_flag && (r_pc < USER_BASE);
`else
  assign w_priv_fault = 1'b0;
  // Mode inputs are intentionally ignored in this build.
  wire w_unused = &{1'b0, bus.kernel_flag, USER_BASE};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_mem_addr    <= RESET_PC;
      r_mem_rd      <= 1'b0;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= 16'h0000;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
      r_cnt         <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.pc_load) begin
            r_pc <= bus.pc_next;
          end else if (bus.fetch_req) begin
            r_busy <= 1'b1;
            if (w_priv_fault) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_pc;
            end
          end
        end

        S_ISSUE, S_WAIT, S_VALID: begin
          if (bus.pc_load) begin
            // Flush: whatever is in flight or presented is dropped.
            r_state       <= S_IDLE;
            r_pc          <= bus.pc_next;
            r_mem_rd      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
          end else if (r_state == S_ISSUE) begin
            r_state  <= S_WAIT;
            r_mem_rd <= 1'b0;
            r_cnt    <= c_CNT_INIT;
          end else if (r_state == S_WAIT) begin
            if (r_cnt == 2'd0) begin
              if (bus.acc_inv) begin
                // Faulting word is never exposed; PC stays on the bad address.
                r_state <= S_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_state       <= S_VALID;
                r_instr       <= bus.mem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end else if (bus.instr_ready) begin
            r_state       <= S_IDLE;
            r_pc          <= r_pc + 16'd1;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
          end
        end

        S_FAULT: begin
          if (bus.pc_load) begin
            r_state <= S_IDLE;
            r_pc    <= bus.pc_next;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
          end else if (bus.fault_clr) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_mem_rd      <= 1'b0;
          r_instr_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_rd      = r_mem_rd;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire
